sr_input_conditioner: RTL and testbench
=======================================

Name: sr_input_conditioner

Overview:
- Conditions two raw, asynchronous push-button inputs (set and reset) into clean, mutually exclusive s/r levels.
- These levels feed the set/reset-input D flip-flop stage directly downstream.
- Each channel is synchronised, then debounced; an arbitration FSM then drives s/r.
- The FSM blocks simultaneous set+reset assertion and flags the conflict.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive clock edges a synchronised input must differ from its debounced value before the debounced value changes (legal range 2..65535)
CNT_W, 16, width of each debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES

Ports:
clk  input  1  single system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
btn_set  input  1  raw set button, asynchronous to clk, may bounce
btn_reset  input  1  raw reset button, asynchronous to clk, may bounce
s  output  1  set level to downstream flip-flop
r  output  1  reset level to downstream flip-flop
set_pulse  output  1  one-cycle strobe on entry to SET
reset_pulse  output  1  one-cycle strobe on entry to RESET
conflict  output  1  high while in LOCKOUT

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (rst_n).
- While rst_n=0:
  - sync flops, debounced values (db_s, db_r) and counters are 0.
  - state is IDLE.
  - s, r, set_pulse, reset_pulse and conflict are all 0.
  - Reset asserted mid-operation clears everything immediately, with no wait for an edge.
  - After release, operation restarts from IDLE on the next rising edge.
- Synchroniser: 2-flop chain per channel; stage-2 output is sy_s / sy_r.
- Debounce, per channel:
  - If sy == db, the counter is cleared to 0.
  - If sy != db and counter < DEBOUNCE_CYCLES-1, the counter increments.
  - If sy != db and counter == DEBOUNCE_CYCLES-1, db <= sy and the counter is cleared.
  - Any single-cycle return to sy == db restarts the count from 0. Glitches shorter than DEBOUNCE_CYCLES cycles are rejected.
- Latency:
  - Call the first edge at which sync stage-1 captures a new raw level edge 0.
  - db changes at edge DEBOUNCE_CYCLES+1.
  - FSM state and outputs change at edge DEBOUNCE_CYCLES+2.
- FSM is Moore, registered state; next state is evaluated from db_s and db_r.
  - IDLE (s=0, r=0):
    - db_s & db_r -> LOCKOUT
    - db_r -> RESET
    - db_s -> SET
    - else stay
  - SET (s=1, r=0):
    - db_r -> LOCKOUT
    - !db_s -> IDLE
    - else stay
  - RESET (s=0, r=1):
    - db_s -> LOCKOUT
    - !db_r -> IDLE
    - else stay
  - LOCKOUT (s=0, r=0, conflict=1):
    - only !db_s & !db_r -> IDLE
    - releasing one button keeps LOCKOUT, so no spurious s or r.
- Output invariants:
  - s & r is never 1.
  - s and r are decoded purely from the state register, glitch-free.
- Pulses:
  - set_pulse = 1 for exactly the first cycle in SET (state==SET, previous state!=SET). reset_pulse is analogous for RESET.
  - Both pulses are registered alongside the state; no pulse fires on entry to IDLE or LOCKOUT.
- Simultaneous db_s and db_r rising in the same cycle from IDLE goes to LOCKOUT, never SET or RESET.
- Counter overflow is impossible: the counter saturates by clearing at DEBOUNCE_CYCLES-1.

Test Plan:
1. Reset, static inputs: rst_n=0 then 1, btn_*=0 for 20 cycles -> s=r=set_pulse=reset_pulse=conflict=0 throughout, state IDLE.
2. Clean set press: DEBOUNCE_CYCLES=4, btn_set rises before edge 0 and is held -> s=1 from edge 6. set_pulse=1 for edge 6 to 7 only. Release -> s=0 six edges after the release edge.
3. Bounce rejection: btn_set toggles 1,0,1,0 with 2-cycle high periods, then stays 0 -> s stays 0 and db_s never changes. A 3-cycle high burst is also rejected; a 4-cycle stable high is accepted.
4. Reset priority/conflict: hold btn_set until s=1, then assert btn_reset -> s=0, r=0, conflict=1. Release btn_set only -> remains LOCKOUT. Release btn_reset -> IDLE, no set_pulse or reset_pulse emitted.
5. Simultaneous press: both buttons rise in the same cycle -> LOCKOUT directly, with s and r never 1 at any cycle.
6. Async reset mid-operation: in SET with s=1, pulse rst_n=0 between edges -> s drops to 0 immediately. After release with btn_set still held, s=1 again at edge 6 and set_pulse fires once.

Source files
------------

// File: rtl/sr_input_conditioner.sv
// sr_input_conditioner: synchronise and debounce set/reset buttons, then arbitrate
// them into mutually exclusive s/r levels with conflict lockout.
module sr_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_set,
  input  logic btn_reset,
  output logic s,
  output logic r,
  output logic set_pulse,
  output logic reset_pulse,
  output logic conflict
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  typedef enum logic [1:0] {S_IDLE, S_SET, S_RESET, S_LOCK} state_t;
  logic [1:0] raw, db;
  logic db_s, db_r;
  state_t state, nxt;
  assign raw = {btn_reset, btn_set};
  assign db_s = db[0];
  assign db_r = db[1];
  for (genvar i = 0; i < 2; i++) begin : g_ch
    logic [1:0] sync;
    logic deb;
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        sync <= '0;
        deb <= 1'b0;
        cnt <= '0;
      end else begin
        sync <= {sync[0], raw[i]};
        if (sync[1] == deb) cnt <= '0;
        else if (cnt == LAST) begin
          deb <= sync[1];
          cnt <= '0;
        end else cnt <= cnt + 1'b1;
      end
    assign db[i] = deb;
  end
  always_comb
    nxt = state == S_IDLE  ? (db_s && db_r ? S_LOCK : db_r ? S_RESET : db_s ? S_SET : S_IDLE) :
          state == S_SET   ? (db_r ? S_LOCK : !db_s ? S_IDLE : S_SET) :
          state == S_RESET ? (db_s ? S_LOCK : !db_r ? S_IDLE : S_RESET) :
                             (!db_s && !db_r ? S_IDLE : S_LOCK);
  // Outputs are registered from nxt so they always mirror the state register.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      s <= 1'b0;
      r <= 1'b0;
      conflict <= 1'b0;
      set_pulse <= 1'b0;
      reset_pulse <= 1'b0;
    end else begin
      state <= nxt;
      s <= nxt == S_SET;
      r <= nxt == S_RESET;
      conflict <= nxt == S_LOCK;
      set_pulse <= nxt == S_SET && state != S_SET;
      reset_pulse <= nxt == S_RESET && state != S_RESET;
    end
endmodule

// File: tb/tb_sr_input_conditioner.sv
// tb_sr_input_conditioner: directed tests of debounce latency, bounce rejection,
// conflict lockout and asynchronous reset.
module tb_sr_input_conditioner;
  logic clk = 1'b0, rst_n = 1'b0, btn_set = 1'b0, btn_reset = 1'b0;
  logic s, r, set_pulse, reset_pulse, conflict;
  int n_chk = 0, n_fail = 0;

  sr_input_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .btn_set(btn_set), .btn_reset(btn_reset),
    .s(s), .r(r), .set_pulse(set_pulse), .reset_pulse(reset_pulse), .conflict(conflict)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int k = 0; k < n; k++) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #3;
    n_chk++;
    if ({s, r, set_pulse, reset_pulse, conflict} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_held: got %b expected 00000", {s, r, set_pulse, reset_pulse, conflict});
    end
    @(negedge clk) rst_n = 1'b1;
    for (int e = 0; e < 20; e++) begin
      step(1);
      n_chk++;
      if ({s, r, set_pulse, reset_pulse, conflict} !== 5'b0) begin
        n_fail++;
        $display("FAIL reset_idle e%0d: got %b expected 00000", e, {s, r, set_pulse, reset_pulse, conflict});
      end
    end
  endtask

  task automatic test_set_press;
    @(negedge clk) btn_set = 1'b1;
    for (int e = 0; e < 9; e++) begin
      step(1);
      n_chk++;
      if (s !== (e >= 6) || set_pulse !== (e == 6) || r !== 1'b0 || conflict !== 1'b0) begin
        n_fail++;
        $display("FAIL set_press e%0d: got s=%b sp=%b r=%b c=%b expected s=%b sp=%b r=0 c=0",
                 e, s, set_pulse, r, conflict, e >= 6, e == 6);
      end
    end
    @(negedge clk) btn_set = 1'b0;
    for (int e = 0; e < 9; e++) begin
      step(1);
      n_chk++;
      if (s !== (e < 6) || set_pulse !== 1'b0) begin
        n_fail++;
        $display("FAIL set_release e%0d: got s=%b sp=%b expected s=%b sp=0", e, s, set_pulse, e < 6);
      end
    end
  endtask

  task automatic test_reset_press;
    @(negedge clk) btn_reset = 1'b1;
    for (int e = 0; e < 9; e++) begin
      step(1);
      n_chk++;
      if (r !== (e >= 6) || reset_pulse !== (e == 6) || s !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_press e%0d: got r=%b rp=%b s=%b expected r=%b rp=%b s=0",
                 e, r, reset_pulse, s, e >= 6, e == 6);
      end
    end
    @(negedge clk) btn_reset = 1'b0;
    for (int e = 0; e < 9; e++) begin
      step(1);
      n_chk++;
      if (r !== (e < 6) || reset_pulse !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_release e%0d: got r=%b rp=%b expected r=%b rp=0", e, r, reset_pulse, e < 6);
      end
    end
  endtask

  task automatic test_bounce;
    logic [15:0] pat;
    pat = 16'b0000_0000_0011_0011;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk) btn_set = pat[k];
      #1;
      n_chk++;
      if (s !== 1'b0 || set_pulse !== 1'b0) begin
        n_fail++;
        $display("FAIL bounce2 k%0d: got s=%b sp=%b expected 0 0", k, s, set_pulse);
      end
    end
    pat = 16'b0000_0000_0000_0111;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk) btn_set = pat[k];
      #1;
      n_chk++;
      if (s !== 1'b0 || set_pulse !== 1'b0) begin
        n_fail++;
        $display("FAIL bounce3 k%0d: got s=%b sp=%b expected 0 0", k, s, set_pulse);
      end
    end
    @(negedge clk) btn_set = 1'b1;
    for (int e = 0; e < 12; e++) begin
      if (e == 4) @(negedge clk) btn_set = 1'b0;
      step(1);
      n_chk++;
      if (s !== (e >= 6 && e <= 9) || set_pulse !== (e == 6)) begin
        n_fail++;
        $display("FAIL stable4 e%0d: got s=%b sp=%b expected s=%b sp=%b",
                 e, s, set_pulse, e >= 6 && e <= 9, e == 6);
      end
    end
  endtask

  task automatic test_conflict;
    @(negedge clk) btn_set = 1'b1;
    step(8);
    n_chk++;
    if (s !== 1'b1) begin
      n_fail++;
      $display("FAIL conflict_pre: got s=%b expected 1", s);
    end
    @(negedge clk) btn_reset = 1'b1;
    for (int e = 0; e < 9; e++) begin
      step(1);
      n_chk++;
      if (s !== (e < 6) || r !== 1'b0 || conflict !== (e >= 6) || reset_pulse !== 1'b0) begin
        n_fail++;
        $display("FAIL conflict_enter e%0d: got s=%b r=%b c=%b rp=%b expected s=%b r=0 c=%b rp=0",
                 e, s, r, conflict, reset_pulse, e < 6, e >= 6);
      end
    end
    @(negedge clk) btn_set = 1'b0;
    for (int e = 0; e < 12; e++) begin
      step(1);
      n_chk++;
      if ({s, r, set_pulse, reset_pulse, conflict} !== 5'b00001) begin
        n_fail++;
        $display("FAIL conflict_hold e%0d: got %b expected 00001", e, {s, r, set_pulse, reset_pulse, conflict});
      end
    end
    @(negedge clk) btn_reset = 1'b0;
    for (int e = 0; e < 10; e++) begin
      step(1);
      n_chk++;
      if ({s, r, set_pulse, reset_pulse} !== 4'b0 || conflict !== (e < 6)) begin
        n_fail++;
        $display("FAIL conflict_exit e%0d: got s=%b r=%b sp=%b rp=%b c=%b expected 0 0 0 0 c=%b",
                 e, s, r, set_pulse, reset_pulse, conflict, e < 6);
      end
    end
  endtask

  task automatic test_simultaneous;
    @(negedge clk) begin btn_set = 1'b1; btn_reset = 1'b1; end
    for (int e = 0; e < 10; e++) begin
      step(1);
      n_chk++;
      if ({s, r, set_pulse, reset_pulse} !== 4'b0 || conflict !== (e >= 6)) begin
        n_fail++;
        $display("FAIL simul e%0d: got s=%b r=%b sp=%b rp=%b c=%b expected 0 0 0 0 c=%b",
                 e, s, r, set_pulse, reset_pulse, conflict, e >= 6);
      end
    end
    @(negedge clk) begin btn_set = 1'b0; btn_reset = 1'b0; end
    for (int e = 0; e < 10; e++) begin
      step(1);
      n_chk++;
      if ({s, r, set_pulse, reset_pulse} !== 4'b0 || conflict !== (e < 6)) begin
        n_fail++;
        $display("FAIL simul_release e%0d: got s=%b r=%b sp=%b rp=%b c=%b expected 0 0 0 0 c=%b",
                 e, s, r, set_pulse, reset_pulse, conflict, e < 6);
      end
    end
  endtask

  task automatic test_async_reset;
    @(negedge clk) btn_set = 1'b1;
    step(8);
    n_chk++;
    if (s !== 1'b1) begin
      n_fail++;
      $display("FAIL async_pre: got s=%b expected 1", s);
    end
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({s, r, set_pulse, reset_pulse, conflict} !== 5'b0) begin
      n_fail++;
      $display("FAIL async_clear: got %b expected 00000", {s, r, set_pulse, reset_pulse, conflict});
    end
    step(2);
    @(negedge clk) rst_n = 1'b1;
    for (int e = 0; e < 10; e++) begin
      step(1);
      n_chk++;
      if (s !== (e >= 6) || set_pulse !== (e == 6)) begin
        n_fail++;
        $display("FAIL async_restart e%0d: got s=%b sp=%b expected s=%b sp=%b",
                 e, s, set_pulse, e >= 6, e == 6);
      end
    end
    @(negedge clk) btn_set = 1'b0;
    step(10);
  endtask

  // s and r must never be asserted together at any instant.
  always @(negedge clk)
    if (rst_n && s && r) begin
      n_chk++;
      n_fail++;
      $display("FAIL exclusive: got s=1 r=1 expected not both");
    end

  initial begin
    test_reset;
    test_set_press;
    step(4);
    test_reset_press;
    step(4);
    test_bounce;
    step(8);
    test_conflict;
    step(4);
    test_simultaneous;
    step(4);
    test_async_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
